// File: rtl/bjp_pred_if.sv
// Request/commit bus of the branch/jump resolver. The slave modport faces the resolver.
interface bjp_pred_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic            i_ready;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [XLEN-1:0] i_imm;
    logic            i_bxx;
    logic            i_jal;
    logic            i_jalr;
    logic [2:0]      i_cmp;
    logic            i_rv32;
    logic            i_pred_taken;
    logic            i_kill;
    logic            cmt_valid;
    logic            cmt_ready;
    logic [XLEN-1:0] cmt_wdat;
    logic            cmt_taken;
    logic            cmt_flush;
    logic [XLEN-1:0] cmt_flush_pc;

    modport master (
        output i_valid, i_pc, i_rs1, i_rs2, i_imm, i_bxx, i_jal, i_jalr, i_cmp, i_rv32,
               i_pred_taken, i_kill, cmt_ready,
        input  i_ready, cmt_valid, cmt_wdat, cmt_taken, cmt_flush, cmt_flush_pc
    );

    modport slave (
        input  i_valid, i_pc, i_rs1, i_rs2, i_imm, i_bxx, i_jal, i_jalr, i_cmp, i_rv32,
               i_pred_taken, i_kill, cmt_ready,
        output i_ready, cmt_valid, cmt_wdat, cmt_taken, cmt_flush, cmt_flush_pc
    );
endinterface

// File: rtl/bjp_pred.sv
// Branch/jump resolver with a registered commit stage and optional 2-bit bimodal BHT.
// Define BJP_PRED_BHT_EN to build the BHT; otherwise lkp_taken is 0 and predictions are ignored.
module bjp_pred #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    bjp_pred_if.slave       bus,
    input  logic [XLEN-1:0] lkp_pc,
    output logic            lkp_taken
);
    localparam int unsigned IDXW = $clog2(BHT_DEPTH);

    logic            accept;
    logic            cmp_res;
    logic            taken;
    logic            pred_eff;
    logic            flush;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] flush_pc;

    logic            cmt_valid_q;
    logic            cmt_taken_q;
    logic            cmt_flush_q;
    logic [XLEN-1:0] cmt_wdat_q;
    logic [XLEN-1:0] cmt_flush_pc_q;

    logic            unused_lkp;

    assign bus.i_ready = ~cmt_valid_q | bus.cmt_ready;
    assign accept      = bus.i_valid & bus.i_ready;
    assign unused_lkp  = ^lkp_pc;

    always_comb begin
        unique case (bus.i_cmp)
            3'b000:  cmp_res = (bus.i_rs1 == bus.i_rs2);
            3'b001:  cmp_res = (bus.i_rs1 != bus.i_rs2);
            3'b100:  cmp_res = ($signed(bus.i_rs1) < $signed(bus.i_rs2));
            3'b101:  cmp_res = ($signed(bus.i_rs1) >= $signed(bus.i_rs2));
            3'b110:  cmp_res = (bus.i_rs1 < bus.i_rs2);
            3'b111:  cmp_res = (bus.i_rs1 >= bus.i_rs2);
            default: cmp_res = 1'b0;
        endcase
    end

    always_comb begin
        taken  = bus.i_jal | bus.i_jalr | (bus.i_bxx & cmp_res);
        link   = bus.i_pc + (bus.i_rv32 ? XLEN'(4) : XLEN'(2));
        target = bus.i_pc + bus.i_imm;
        if (bus.i_jalr) begin
            target = (bus.i_rs1 + bus.i_imm) & ~XLEN'(1);
        end
        flush    = 1'b0;
        flush_pc = link;
        if (bus.i_jal | bus.i_jalr) begin
            flush    = 1'b1;
            flush_pc = target;
        end else if (bus.i_bxx) begin
            flush    = (taken != pred_eff);
            flush_pc = taken ? target : link;
        end
    end

    // Kill wins over a same-cycle accept; held data is simply left stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmt_valid_q    <= 1'b0;
            cmt_taken_q    <= 1'b0;
            cmt_flush_q    <= 1'b0;
            cmt_wdat_q     <= '0;
            cmt_flush_pc_q <= '0;
        end else if (bus.i_kill) begin
            cmt_valid_q <= 1'b0;
        end else if (accept) begin
            cmt_valid_q    <= 1'b1;
            cmt_taken_q    <= taken;
            cmt_flush_q    <= flush;
            cmt_wdat_q     <= link;
            cmt_flush_pc_q <= flush_pc;
        end else if (bus.cmt_ready) begin
            cmt_valid_q <= 1'b0;
        end
    end

    assign bus.cmt_valid    = cmt_valid_q;
    assign bus.cmt_taken    = cmt_taken_q;
    assign bus.cmt_flush    = cmt_flush_q;
    assign bus.cmt_wdat     = cmt_wdat_q;
    assign bus.cmt_flush_pc = cmt_flush_pc_q;

`ifdef BJP_PRED_BHT_EN
    logic [1:0]      bht_q [BHT_DEPTH];
    logic [IDXW-1:0] lkp_idx;
    logic [IDXW-1:0] upd_idx;
    logic [1:0]      cnt;
    logic [1:0]      cnt_nxt;
    logic            bht_upd;

    assign pred_eff  = bus.i_pred_taken;
    assign lkp_idx   = lkp_pc[IDXW:1];
    assign upd_idx   = bus.i_pc[IDXW:1];
    // Killed branches still train: the outcome is architecturally resolved.
    assign bht_upd   = accept & bus.i_bxx;
    assign lkp_taken = bht_q[lkp_idx][1];

    always_comb begin
        cnt     = bht_q[upd_idx];
        cnt_nxt = cnt;
        if (taken && cnt != 2'b11) begin
            cnt_nxt = cnt + 2'd1;
        end else if (!taken && cnt != 2'b00) begin
            cnt_nxt = cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_upd) begin
            bht_q[upd_idx] <= cnt_nxt;
        end
    end
`else
    logic [IDXW-1:0] unused_idx;
    logic            unused_pred;

    assign pred_eff    = 1'b0;
    assign lkp_taken   = 1'b0;
    assign unused_idx  = lkp_pc[IDXW:1];
    assign unused_pred = bus.i_pred_taken;
`endif
endmodule

// File: tb/tb_bjp_pred.sv
// Directed bench for bjp_pred; expectations follow BJP_PRED_BHT_EN when it is defined.
module tb_bjp_pred;
    localparam int unsigned XLEN = 32;
`ifdef BJP_PRED_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] lkp_pc;
    logic        lkp_taken;
    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    bjp_pred_if #(.XLEN(XLEN)) bus ();

    bjp_pred #(
        .XLEN     (XLEN),
        .BHT_DEPTH(64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .lkp_pc   (lkp_pc),
        .lkp_taken(lkp_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [66:0] obs();
        return {bus.cmt_valid, bus.cmt_taken, bus.cmt_flush, bus.cmt_wdat, bus.cmt_flush_pc};
    endfunction

    task automatic idle();
        bus.i_valid = 0; bus.i_bxx = 0; bus.i_jal = 0; bus.i_jalr = 0; bus.i_kill = 0;
        bus.i_cmp = 0; bus.i_pc = 0; bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_imm = 0;
        bus.i_rv32 = 1; bus.i_pred_taken = 0;
    endtask

    // cls = {bxx, jal, jalr}
    task automatic drive(input logic [2:0] cls, input logic [2:0] cmp, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic rv32, input logic pred);
        bus.i_valid = 1; bus.i_kill = 0;
        {bus.i_bxx, bus.i_jal, bus.i_jalr} = cls;
        bus.i_cmp = cmp; bus.i_pc = pc; bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_imm = imm;
        bus.i_rv32 = rv32; bus.i_pred_taken = pred;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(3'b010, 3'b000, 32'h10, 32'h0, 32'h0, 32'h40, 1, 0);
        step();
        step();
        total_cnt++;
        if (obs() !== 67'd0) $display("FAIL reset_out: got %h exp 0", obs());
        else pass_cnt++;
        total_cnt++;
        if (bus.i_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", bus.i_ready);
        else pass_cnt++;
        rst_n = 1;
        idle();
        lkp_pc = 32'h8;
        step();
        total_cnt++;
        if ({obs(), lkp_taken} !== 68'd0) $display("FAIL reset_idle: got %h exp 0", {obs(), lkp_taken});
        else pass_cnt++;
    endtask

    task automatic test_beq();
        logic [66:0] exp;
        drive(3'b100, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1, 0);
        step();
        idle();
        exp = {1'b1, 1'b1, 1'b1, 32'h104, 32'h120};
        total_cnt++;
        if (obs() !== exp) $display("FAIL beq: got %h exp %h", obs(), exp);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.cmt_valid !== 1'b0) $display("FAIL beq_drain: got %b exp 0", bus.cmt_valid);
        else pass_cnt++;
    endtask

    task automatic test_jumps();
        logic [66:0] exp;
        drive(3'b001, 3'b000, 32'h40, 32'h2003, 32'h0, 32'h10, 0, 0);
        step();
        exp = {1'b1, 1'b1, 1'b1, 32'h42, 32'h2012};
        total_cnt++;
        if (obs() !== exp) $display("FAIL jalr: got %h exp %h", obs(), exp);
        else pass_cnt++;
        drive(3'b010, 3'b000, 32'h1000, 32'hdead, 32'h0, 32'hffff_fff0, 1, 1);
        step();
        idle();
        exp = {1'b1, 1'b1, 1'b1, 32'h1004, 32'h0ff0};
        total_cnt++;
        if (obs() !== exp) $display("FAIL jal: got %h exp %h", obs(), exp);
        else pass_cnt++;
        step();
    endtask

    task automatic test_compare();
        logic [2:0]  cmps [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] a    [8] = '{32'hffff_ffff, 32'hffff_ffff, 32'd1, 32'd1, 32'd3, 32'd5, 32'd5, 32'd7};
        logic [31:0] b    [8] = '{32'd1, 32'd1, 32'hffff_ffff, 32'hffff_ffff, 32'd4, 32'd5, 32'd5, 32'd7};
        logic        pred [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        tkn  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [66:0] exp;
        logic        exp_flush;
        for (int i = 0; i < 8; i++) begin
            drive(3'b100, cmps[i], 32'h300, a[i], b[i], 32'h8, 1, pred[i]);
            step();
            exp_flush = tkn[i] ^ (BHT & pred[i]);
            exp = {1'b1, tkn[i], exp_flush, 32'h304, tkn[i] ? 32'h308 : 32'h304};
            total_cnt++;
            if (obs() !== exp) $display("FAIL cmp%0d: got %h exp %h", i, obs(), exp);
            else pass_cnt++;
        end
        idle();
        step();
    endtask

    task automatic test_no_class();
        drive(3'b000, 3'b000, 32'h500, 32'd1, 32'd1, 32'h40, 0, 1);
        step();
        idle();
        total_cnt++;
        if (obs()[66:32] !== {1'b1, 1'b0, 1'b0, 32'h502})
            $display("FAIL no_class: got %h exp %h", obs()[66:32], {1'b1, 1'b0, 1'b0, 32'h502});
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [66:0] held;
        logic [66:0] exp;
        bus.cmt_ready = 0;
        drive(3'b010, 3'b000, 32'h600, 32'h0, 32'h0, 32'h40, 1, 0);
        step();
        held = {1'b1, 1'b1, 1'b1, 32'h604, 32'h640};
        total_cnt++;
        if (obs() !== held) $display("FAIL stall_load: got %h exp %h", obs(), held);
        else pass_cnt++;
        drive(3'b001, 3'b000, 32'h700, 32'h1000, 32'h0, 32'h4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({bus.i_ready, obs()} !== {1'b0, held})
                $display("FAIL stall%0d: got %h exp %h", i, {bus.i_ready, obs()}, {1'b0, held});
            else pass_cnt++;
            step();
        end
        bus.cmt_ready = 1;
        #1;
        total_cnt++;
        if (bus.i_ready !== 1'b1) $display("FAIL stall_release: got %b exp 1", bus.i_ready);
        else pass_cnt++;
        step();
        idle();
        exp = {1'b1, 1'b1, 1'b1, 32'h702, 32'h1004};
        total_cnt++;
        if (obs() !== exp) $display("FAIL b2b: got %h exp %h", obs(), exp);
        else pass_cnt++;
        step();
    endtask

    task automatic test_kill();
        bus.cmt_ready = 0;
        drive(3'b010, 3'b000, 32'h20, 32'h0, 32'h0, 32'h8, 1, 0);
        step();
        idle();
        bus.i_kill = 1;
        step();
        total_cnt++;
        if (bus.cmt_valid !== 1'b0) $display("FAIL kill_held: got %b exp 0", bus.cmt_valid);
        else pass_cnt++;
        bus.i_kill = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        bus.cmt_ready = 1;
        lkp_pc = 32'h8;
        drive(3'b100, 3'b000, 32'h8, 32'd1, 32'd1, 32'h10, 1, 0);
        bus.i_kill = 1;
        step();
        idle();
        total_cnt++;
        if ({bus.cmt_valid, lkp_taken} !== {1'b0, BHT})
            $display("FAIL kill_accept: got %b exp %b", {bus.cmt_valid, lkp_taken}, {1'b0, BHT});
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_stall();
        bus.cmt_ready = 0;
        drive(3'b100, 3'b000, 32'h8, 32'd1, 32'd1, 32'h10, 1, 0);
        step();
        idle();
        total_cnt++;
        if ({bus.cmt_valid, lkp_taken} !== {1'b1, BHT})
            $display("FAIL pre_rst: got %b exp %b", {bus.cmt_valid, lkp_taken}, {1'b1, BHT});
        else pass_cnt++;
        step();
        step();
        rst_n = 0;
        drive(3'b100, 3'b000, 32'h8, 32'd1, 32'd1, 32'h10, 1, 0);
        step();
        total_cnt++;
        if ({bus.i_ready, obs(), lkp_taken} !== {1'b1, 67'd0, 1'b0})
            $display("FAIL mid_rst: got %h exp %h", {bus.i_ready, obs(), lkp_taken}, {1'b1, 68'd0});
        else pass_cnt++;
        rst_n = 1;
        idle();
        bus.cmt_ready = 1;
        step();
    endtask

    task automatic test_bht();
        logic dir  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic prd  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic prev;
        logic exp;
        prev = 1'b0;
        lkp_pc = 32'h8;
        for (int i = 0; i < 8; i++) begin
            drive(3'b100, 3'b000, 32'h8, 32'd9, dir[i] ? 32'd9 : 32'd3, 32'h40, 1, 0);
            #1;
            total_cnt++;
            if (lkp_taken !== prev) $display("FAIL bht_pre%0d: got %b exp %b", i, lkp_taken, prev);
            else pass_cnt++;
            step();
            exp = BHT & prd[i];
            total_cnt++;
            if (lkp_taken !== exp) $display("FAIL bht_upd%0d: got %b exp %b", i, lkp_taken, exp);
            else pass_cnt++;
            prev = exp;
            if (i == 3) begin
                idle();
                lkp_pc = 32'h88;
                #1;
                total_cnt++;
                if (lkp_taken !== BHT) $display("FAIL bht_alias: got %b exp %b", lkp_taken, BHT);
                else pass_cnt++;
                lkp_pc = 32'ha;
                #1;
                total_cnt++;
                if (lkp_taken !== 1'b0) $display("FAIL bht_other: got %b exp 0", lkp_taken);
                else pass_cnt++;
                lkp_pc = 32'h8;
            end
        end
        drive(3'b100, 3'b000, 32'h8, 32'd9, 32'd9, 32'h40, 1, 1);
        step();
        idle();
        total_cnt++;
        if (bus.cmt_flush !== ~BHT) $display("FAIL pred_hit: got %b exp %b", bus.cmt_flush, ~BHT);
        else pass_cnt++;
        step();
    endtask

    initial begin
        bus.cmt_ready = 1;
        lkp_pc = 0;
        idle();
        test_reset();
        test_beq();
        test_jumps();
        test_compare();
        test_no_class();
        test_back_to_back();
        test_kill();
        test_reset_mid_stall();
        test_bht();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bjp_pred.md
BJP_PRED -- requirements
Module: bjp_pred

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data, PC and immediate width.
REQ-002 Parameter BHT_DEPTH, default 64, power of two >= 4, SHALL set the number of 2-bit counters; IDXW = log2(BHT_DEPTH).
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_valid  in  1  request valid; i_ready  out  1  request accepted when i_valid & i_ready.
REQ-006 i_pc, i_rs1, i_rs2, i_imm  in  XLEN each  instruction PC, operands, sign-extended byte-offset immediate.
REQ-007 i_bxx, i_jal, i_jalr  in  1 each  one-hot op class; i_cmp  in  3  funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
REQ-008 i_rv32  in  1  1 = 4-byte instruction, 0 = 2-byte; i_pred_taken  in  1  fetch-time prediction carried with the instruction.
REQ-009 i_kill  in  1  discard the held result and any same-cycle accept.
REQ-010 cmt_valid  out  1; cmt_ready  in  1  result handshake.
REQ-011 cmt_wdat  out  XLEN link value; cmt_taken  out  1; cmt_flush  out  1; cmt_flush_pc  out  XLEN.
REQ-012 lkp_pc  in  XLEN fetch lookup PC; lkp_taken  out  1  prediction, combinational.

Function
REQ-013 i_ready SHALL equal ~cmt_valid | cmt_ready.
REQ-014 An accepted request SHALL appear on the cmt_* outputs exactly one cycle later; cmt_* SHALL hold stable while cmt_valid & ~cmt_ready.
REQ-015 cmt_valid SHALL be set on accept, cleared on cmt_valid & cmt_ready without a new accept, and remain set on back-to-back accept.
REQ-016 taken SHALL be: i_jal | i_jalr | (i_bxx & compare per i_cmp); signed compares use two's complement; undefined i_cmp values give not taken.
REQ-017 Target SHALL be i_pc+i_imm for jal/bxx and (i_rs1+i_imm) with bit 0 cleared for jalr, modulo 2^XLEN.
REQ-018 cmt_wdat SHALL be i_pc+4 if i_rv32 else i_pc+2, modulo 2^XLEN, for all op classes.
REQ-019 jal and jalr SHALL always assert cmt_flush with cmt_flush_pc = target.
REQ-020 For bxx, cmt_flush SHALL assert iff taken != i_pred_taken; cmt_flush_pc = target if taken, else cmt_wdat value.
REQ-021 Counter index SHALL be pc[IDXW:1] for both lookup and update.
REQ-022 On accept of bxx, the indexed counter SHALL increment (taken) or decrement (not taken), saturating at 3 and 0.
REQ-023 lkp_taken SHALL be counter[idx(lkp_pc)] bit 1; a same-cycle update of that index SHALL NOT be visible until the next cycle.
REQ-024 i_kill SHALL clear cmt_valid next cycle and take precedence over a simultaneous accept; a killed request SHALL still update the BHT (the branch is architecturally resolved).
REQ-025 With no op class asserted, an accepted request SHALL produce cmt_valid with cmt_taken=0, cmt_flush=0.

Reset
REQ-026 With rst_n low at a clock edge: cmt_valid=0, cmt_taken=0, cmt_flush=0, cmt_wdat=0, cmt_flush_pc=0, all counters=01 (weakly not taken).
REQ-027 Reset SHALL override any accept, kill or update in the same cycle; i_ready SHALL read 1 after reset.

Configuration
REQ-028 Macro BJP_PRED_BHT_EN defined: BHT built as above.
REQ-029 BJP_PRED_BHT_EN undefined: no counter storage; lkp_taken tied 0; i_pred_taken ignored and treated as 0, so bxx flushes iff taken.

Verification
REQ-030 beq, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle cmt_taken=1, cmt_flush=1, cmt_flush_pc=0x120, cmt_wdat=0x104.
REQ-031 jalr rs1=0x2003, imm=0x10, i_rv32=0, pc=0x40 -> cmt_flush_pc=0x2012, cmt_wdat=0x42, cmt_flush=1.
REQ-032 Four taken bxx at pc=0x8 (after reset): lkp_pc=0x8 reads 0 -> 1 after first update, stays 1; then four not-taken -> 0 after second not-taken.
REQ-033 cmt_ready=0 for 3 cycles with result held -> i_ready=0, cmt_* unchanged; cmt_ready=1 with new i_valid -> back-to-back, cmt_valid stays 1.
REQ-034 blt rs1=0xFFFFFFFF, rs2=1 -> taken; bltu same operands -> not taken, pred=1 -> flush to pc+4.
REQ-035 i_valid and i_kill in same cycle -> cmt_valid=0 next cycle, BHT updated; rst_n low mid-stall -> all outputs and counters return to reset values.
